systolic_sample_feeder: RTL

Upstream stage of the systolic interpolator array. It accepts non-uniform sample words from the acquisition side through a valid/ready handshake and buffers them in a small FIFO. It presents one word per slot of `SLOT_CYCLES` clk30x cycles on `outputword`, which drives `inputword` of the first systolic PE. It also publishes slot timing (`slot_start`, `word_index`, `frame_start`) aligned with the PE's internal 30-cycle count and 8-word coefficient rotation.

---
 rtl/systolic_pkg.sv | 13 +
 rtl/sample_fifo.sv | 47 ++++
 rtl/systolic_sample_feeder.sv | 83 ++++++++
 3 files changed

// File: rtl/systolic_pkg.sv
// rtl/systolic_pkg.sv - shared slot/frame constants for the systolic interpolator array
package systolic_pkg;

  localparam int WORDLENGTH      = 16;
  localparam int SLOT_CYCLES     = 30;
  localparam int WORDS_PER_FRAME = 8;

  // Counter width that never collapses to zero bits for degenerate sizes.
  function automatic int clog2_min1(input int value);
    return (value > 1) ? $clog2(value) : 1;
  endfunction

endpackage

// File: rtl/sample_fifo.sv
// rtl/sample_fifo.sv - synchronous FIFO with wrap-bit pointers for the sample feeder
module sample_fifo #(
  parameter int WORDLENGTH = 16,
  parameter int FIFO_DEPTH = 4
) (
  input  logic                          clk30x,
  input  logic                          reset,
  input  logic                          push,
  input  logic                          pop,
  input  logic [WORDLENGTH-1:0]         din,
  output logic [WORDLENGTH-1:0]         dout,
  output logic                          full,
  output logic                          empty,
  output logic [$clog2(FIFO_DEPTH):0]   level
);

  localparam int AW = $clog2(FIFO_DEPTH);

  logic [AW:0]           wr_ptr;
  logic [AW:0]           rd_ptr;
  logic [WORDLENGTH-1:0] mem [FIFO_DEPTH];
  logic                  do_push;
  logic                  do_pop;

  // Same index with differing wrap bits means the writer has lapped the reader.
  assign full    = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
  assign empty   = (wr_ptr == rd_ptr);
  assign level   = wr_ptr - rd_ptr;
  assign dout    = mem[rd_ptr[AW-1:0]];
  assign do_push = push && !full;
  assign do_pop  = pop && !empty;

  always_ff @(posedge clk30x) begin
    if (reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
    end
  end

  always_ff @(posedge clk30x) begin
    if (do_push) mem[wr_ptr[AW-1:0]] <= din;
  end

endmodule

// File: rtl/systolic_sample_feeder.sv
// rtl/systolic_sample_feeder.sv - presents one buffered sample per slot to the first systolic PE
module systolic_sample_feeder
  import systolic_pkg::*;
#(
  parameter int WORDLENGTH      = systolic_pkg::WORDLENGTH,
  parameter int SLOT_CYCLES     = systolic_pkg::SLOT_CYCLES,
  parameter int WORDS_PER_FRAME = systolic_pkg::WORDS_PER_FRAME,
  parameter int FIFO_DEPTH      = 4,
  localparam int WIW            = clog2_min1(WORDS_PER_FRAME),
  localparam int LW             = $clog2(FIFO_DEPTH) + 1
) (
  input  logic                  clk30x,
  input  logic                  reset,
  input  logic [WORDLENGTH-1:0] in_word,
  input  logic                  in_valid,
  output logic                  in_ready,
  output logic [WORDLENGTH-1:0] outputword,
  output logic                  slot_start,
  output logic [WIW-1:0]        word_index,
  output logic                  frame_start,
  output logic                  underrun,
  output logic [LW-1:0]         fifo_level
);

  localparam int SCW = clog2_min1(SLOT_CYCLES);
  localparam logic [SCW-1:0] SLOT_LAST = SCW'(SLOT_CYCLES - 1);
  localparam logic [WIW-1:0] WORD_LAST = WIW'(WORDS_PER_FRAME - 1);

  logic [SCW-1:0]        slot_cnt;
  logic                  armed;
  logic                  boundary;
  logic                  fifo_full;
  logic                  fifo_empty;
  logic                  fifo_push;
  logic                  fifo_pop;
  logic [WORDLENGTH-1:0] fifo_dout;

  assign boundary    = (slot_cnt == SLOT_LAST);
  assign in_ready    = !fifo_full;
  assign fifo_push   = in_valid && in_ready;
  assign fifo_pop    = boundary && !fifo_empty;
  assign slot_start  = (slot_cnt == '0);
  assign frame_start = slot_start && (word_index == '0);

  sample_fifo #(
    .WORDLENGTH (WORDLENGTH),
    .FIFO_DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk30x (clk30x),
    .reset  (reset),
    .push   (fifo_push),
    .pop    (fifo_pop),
    .din    (in_word),
    .dout   (fifo_dout),
    .full   (fifo_full),
    .empty  (fifo_empty),
    .level  (fifo_level)
  );

  // Reset parks the counters one cycle before wrap so the first live edge opens slot 0 of a frame.
  always_ff @(posedge clk30x) begin
    if (reset) begin
      slot_cnt   <= SLOT_LAST;
      word_index <= WORD_LAST;
      outputword <= '0;
      armed      <= 1'b0;
      underrun   <= 1'b0;
    end else if (boundary) begin
      slot_cnt   <= '0;
      word_index <= word_index + 1'b1;
      if (!fifo_empty) begin
        outputword <= fifo_dout;
        armed      <= 1'b1;
      end else begin
        outputword <= '0;
        if (armed) underrun <= 1'b1;
      end
    end else begin
      slot_cnt <= slot_cnt + 1'b1;
    end
  end

endmodule
